// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port among NREQ requesters.
//   A grant covers one packet or BURST beats, whichever comes first. It is
//   revoked after TIMEOUT idle cycles if the granted requester stops
//   presenting data. There is always one IDLE cycle between grants.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   req_valid_i  per-requester beat valid
//   req_data_i   per-requester data, requester k at [k*WIDTH +: WIDTH]
//   req_last_i   per-requester end-of-packet, qualified by valid
//   req_ready_o  per-requester ready (only the granted requester, when not full)
//   full_i       FIFO full flag
//   wr_en_o      FIFO write enable
//   wdata_o      FIFO write data (zero when not writing)
//   gnt_o        one-hot current grant, zero while idle
//   busy_o       high while a grant is held
module fifo_wr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  input  logic [NREQ-1:0]       req_last_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic                  full_i,
  output logic                  wr_en_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   gnt_idx_reg, gnt_idx_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [TW-1:0]   idle_cnt_reg, idle_cnt_next;

  logic            any_valid;
  logic [IW-1:0]   sel_idx;
  logic            vld_g, last_g, xfer, live;
  logic [WIDTH-1:0] data_g;

  // (base + off) mod NREQ for base < NREQ and off <= NREQ
  function automatic logic [IW-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin pick: scan from farthest to nearest so the first set bit
  // after the pointer is the one that survives.
  always_comb begin
    any_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req_valid_i[wrap_idx(int'(ptr_reg), i)]) begin
        any_valid = 1'b1;
        sel_idx   = wrap_idx(int'(ptr_reg), i);
      end
    end
  end

  assign vld_g  = req_valid_i[gnt_idx_reg];
  assign last_g = req_last_i[gnt_idx_reg];
  assign data_g = req_data_i[gnt_idx_reg*WIDTH +: WIDTH];

  // Outputs are additionally gated by rst_i so they drop the instant reset
  // rises, independent of how the register reset propagates.
  assign live = (state_reg == GRANT) && !rst_i;
  assign xfer = live && vld_g && !full_i;

  always_comb begin
    state_next    = state_reg;
    gnt_idx_next  = gnt_idx_reg;
    ptr_next      = ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    wr_en_o       = 1'b0;
    wdata_o       = '0;
    req_ready_o   = '0;
    gnt_o         = '0;
    busy_o        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          state_next    = GRANT;
          gnt_idx_next  = sel_idx;
          ptr_next      = sel_idx;
          beat_cnt_next = '0;
          idle_cnt_next = '0;
        end
      end
      GRANT: begin
        busy_o                   = live;
        gnt_o[gnt_idx_reg]       = live;
        req_ready_o[gnt_idx_reg] = live && !full_i;
        wr_en_o                  = xfer;
        if (xfer) wdata_o = data_g;

        if (xfer) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          idle_cnt_next = '0;
          // last and burst limit on the same beat give one release
          if (last_g || beat_cnt_reg == BEAT_LAST) state_next = IDLE;
        end else if (!full_i) begin
          // Requester idle; a full FIFO never counts toward the timeout
          if (idle_cnt_reg == IDLE_LAST) state_next = IDLE;
          else idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      gnt_idx_reg  <= '0;
      ptr_reg      <= IW'(NREQ - 1);
      beat_cnt_reg <= '0;
      idle_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_idx_reg  <= gnt_idx_next;
      ptr_reg      <= ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (WIDTH=8, NREQ=4, BURST=4, TIMEOUT=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fifo_wr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  req_valid_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_last_i = '0;
  logic [3:0]  req_ready_o;
  logic        full_i = 1'b0;
  logic        wr_en_o;
  logic [7:0]  wdata_o;
  logic [3:0]  gnt_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .BURST(4), .TIMEOUT(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
    .req_last_i (req_last_i),
    .req_ready_o(req_ready_o),
    .full_i     (full_i),
    .wr_en_o    (wr_en_o),
    .wdata_o    (wdata_o),
    .gnt_o      (gnt_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  gnt;
    logic        wr;
    logic [7:0]  wdata;
    logic [3:0]  ready;
    logic        busy;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic [3:0] l,
                              logic f, logic [3:0] g, logic w, logic [7:0] wd,
                              logic [3:0] rd, logic b);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.last = l; x.full = f;
    x.gnt = g; x.wr = w; x.wdata = wd; x.ready = rd; x.busy = b;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0; full_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Requester 0 sends 0x10..0x13; FIFO full for nfull cycles after the 2nd beat
  task automatic backpressure(input int nfull);
    int b;
    logic [7:0] got[$];
    logic exp_wr;
    b = 0;
    for (int c = 0; c <= 5 + nfull; c++) begin
      @(negedge clk_i);
      req_valid_i = (b < 4) ? 4'b0001 : 4'b0000;
      req_data_i  = {8'hEE, 8'hDD, 8'hCC, 8'(8'h10 + b)};
      req_last_i  = (b == 3) ? 4'b0001 : 4'b0000;
      full_i      = (c >= 3 && c < 3 + nfull);
      #1;
      exp_wr = (c == 1 || c == 2 || c == 3 + nfull || c == 4 + nfull);
      chk($sformatf("bp%0d_gnt_c%0d", nfull, c), 32'(gnt_o),
          (c >= 1 && c <= 4 + nfull) ? 32'h1 : 32'h0);
      chk($sformatf("bp%0d_wr_c%0d", nfull, c), 32'(wr_en_o), 32'(exp_wr));
      chk($sformatf("bp%0d_rdy_c%0d", nfull, c), 32'(req_ready_o), 32'(exp_wr));
      if (wr_en_o) got.push_back(wdata_o);
      if (req_valid_i[0] && req_ready_o[0]) b++;
    end
    full_i = 1'b0;
    chk($sformatf("bp%0d_count", nfull), 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("bp%0d_data%0d", nfull, i), 32'(got[i]), 32'(8'h10 + i));
    $display("backpressure full=%0d: %0d writes", nfull, got.size());
  endtask

  initial begin
    int writes;
    logic [3:0] eg;
    logic       ew;

    // {lane3,lane2,lane1,lane0}
    tbl[0]  = mk(1, 4'hF, 32'h44332211, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[1]  = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[2]  = mk(0, 4'h2, 32'h3322A111, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[3]  = mk(0, 4'h2, 32'h3322A111, 4'h0, 0, 4'h2, 1, 8'hA1, 4'h2, 1);
    tbl[4]  = mk(0, 4'h2, 32'h3322A211, 4'h0, 0, 4'h2, 1, 8'hA2, 4'h2, 1);
    tbl[5]  = mk(0, 4'h2, 32'h3322A311, 4'h2, 0, 4'h2, 1, 8'hA3, 4'h2, 1);
    tbl[6]  = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[7]  = mk(0, 4'h1, 32'h00000055, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[8]  = mk(0, 4'h5, 32'h00770056, 4'h1, 0, 4'h1, 1, 8'h56, 4'h1, 1);
    tbl[9]  = mk(0, 4'h5, 32'h00770056, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[10] = mk(0, 4'h5, 32'h00770056, 4'h4, 0, 4'h4, 1, 8'h77, 4'h4, 1);
    tbl[11] = mk(0, 4'h1, 32'h00770058, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[12] = mk(0, 4'h1, 32'h00770058, 4'h0, 1, 4'h1, 0, 8'h00, 4'h0, 1);
    tbl[13] = mk(0, 4'h1, 32'h00770058, 4'h1, 0, 4'h1, 1, 8'h58, 4'h1, 1);
    tbl[14] = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[15] = mk(0, 4'h8, 32'hD0000000, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[16] = mk(0, 4'h8, 32'hD0000000, 4'h0, 0, 4'h8, 1, 8'hD0, 4'h8, 1);
    tbl[17] = mk(0, 4'h8, 32'hD1000000, 4'h0, 0, 4'h8, 1, 8'hD1, 4'h8, 1);
    tbl[18] = mk(0, 4'h8, 32'hD2000000, 4'h0, 0, 4'h8, 1, 8'hD2, 4'h8, 1);
    tbl[19] = mk(0, 4'h8, 32'hD3000000, 4'h8, 0, 4'h8, 1, 8'hD3, 4'h8, 1);
    tbl[20] = mk(0, 4'h8, 32'hE0000000, 4'h0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
    tbl[21] = mk(0, 4'h8, 32'hE0000000, 4'h0, 0, 4'h8, 1, 8'hE0, 4'h8, 1);
    tbl[22] = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 4'h8, 0, 8'h00, 4'h8, 1);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk_i);
      rst_i = tbl[i].rst; req_valid_i = tbl[i].valid; req_data_i = tbl[i].data;
      req_last_i = tbl[i].last; full_i = tbl[i].full;
      #1;
      chk($sformatf("v%0d_gnt", i),   32'(gnt_o),       32'(tbl[i].gnt));
      chk($sformatf("v%0d_wr", i),    32'(wr_en_o),     32'(tbl[i].wr));
      chk($sformatf("v%0d_wdata", i), 32'(wdata_o),     32'(tbl[i].wdata));
      chk($sformatf("v%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].ready));
      chk($sformatf("v%0d_busy", i),  32'(busy_o),      32'(tbl[i].busy));
      $display("vec %0d: gnt=%b wr=%b wdata=%h ready=%b busy=%b",
               i, gnt_o, wr_en_o, wdata_o, req_ready_o, busy_o);
    end

    // Round robin: all valid, no last. Idle at c%5==0, then 4 writes per grant.
    do_reset();
    writes = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk_i);
      req_valid_i = 4'hF; req_data_i = 32'hC3C2C1C0; req_last_i = 4'h0; full_i = 1'b0;
      #1;
      ew = (c % 5 != 0);
      eg = ew ? 4'(1 << ((c / 5) % 4)) : 4'h0;
      chk($sformatf("rr_gnt_c%0d", c), 32'(gnt_o), 32'(eg));
      chk($sformatf("rr_wr_c%0d", c), 32'(wr_en_o), 32'(ew));
      if (ew) chk($sformatf("rr_wdata_c%0d", c), 32'(wdata_o), 32'(8'hC0 + (c / 5) % 4));
      if (wr_en_o && c < 20) writes++;
    end
    chk("rr_writes_20cyc", 32'(writes), 32'd16);
    $display("round robin: %0d writes in 20 cycles", writes);

    do_reset();
    backpressure(3);
    do_reset();
    backpressure(12);

    // Timeout: req 2 sends one beat then goes quiet; req 3 waits.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      req_valid_i = (c < 2) ? 4'b0100 : 4'b1000;
      req_data_i  = 32'h3B2A0000;
      req_last_i  = 4'h0;
      #1;
      eg = (c >= 1 && c <= 9) ? 4'b0100 : (c == 11) ? 4'b1000 : 4'b0000;
      chk($sformatf("to_gnt_c%0d", c), 32'(gnt_o), 32'(eg));
      chk($sformatf("to_wr_c%0d", c), 32'(wr_en_o), 32'(c == 1 || c == 11));
      chk($sformatf("to_rdy_c%0d", c), 32'(req_ready_o), 32'(eg));
    end
    $display("timeout: gnt=%b after release", gnt_o);

    // Asynchronous reset in the middle of a burst
    do_reset();
    @(negedge clk_i);
    req_valid_i = 4'b0001; req_data_i = 32'h00000099; req_last_i = 4'h0;
    @(negedge clk_i);
    #1;
    chk("ar_wr_before", 32'(wr_en_o), 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    chk("ar_wr",    32'(wr_en_o),     32'd0);
    chk("ar_wdata", 32'(wdata_o),     32'd0);
    chk("ar_ready", 32'(req_ready_o), 32'd0);
    chk("ar_gnt",   32'(gnt_o),       32'd0);
    chk("ar_busy",  32'(busy_o),      32'd0);
    $display("async reset: wr=%b gnt=%b busy=%b", wr_en_o, gnt_o, busy_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's FIFO (wr_en/wdata/full interface) among NREQ requesters.
- Each requester presents packets on a valid/ready handshake.
- A grant is held for one packet, up to BURST beats, so writes from different requesters interleave at packet/burst granularity.
- Sits in the write-clock domain directly in front of the FIFO write port.

Parameters:
WIDTH, 8, data width of each requester and of the FIFO write data
NREQ, 4, number of requesters (2..8)
BURST, 4, maximum beats written per grant before rotation
TIMEOUT, 8, idle cycles (granted requester not valid) before the grant is revoked

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
req_valid_i  input  NREQ  per-requester beat valid
req_data_i  input  NREQ*WIDTH  per-requester data; requester k occupies bits [k*WIDTH +: WIDTH]
req_last_i  input  NREQ  per-requester end-of-packet marker, qualified by valid
req_ready_o  output  NREQ  per-requester ready; a beat transfers when valid&ready
full_i  input  1  FIFO full flag
wr_en_o  output  1  FIFO write enable
wdata_o  output  WIDTH  FIFO write data
gnt_o  output  NREQ  one-hot current grant, all-zero when idle
busy_o  output  1  high while in GRANT state

Behaviour:
- Reset (async, immediate):
  - state=IDLE, gnt_o=0, busy_o=0, beat counter=0, idle counter=0.
  - Round-robin pointer = NREQ-1, so requester 0 has top priority first.
  - wr_en_o=0, wdata_o=0, req_ready_o=0 as soon as rst_i rises, including mid-burst.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid_i bit is set, select the first set bit searching from pointer+1 upward with wrap mod NREQ.
  - Next edge: gnt_o=one-hot(selected), pointer=selected, state=GRANT, beat and idle counters cleared.
  - No valid: stay in IDLE.
  - Arbitration latency is exactly one cycle from valid seen in IDLE to gnt_o.
- GRANT, with g the granted index:
  - req_ready_o[g] = ~full_i. All other ready bits are 0. These are combinational from registered state.
  - wr_en_o = req_valid_i[g] & ~full_i, combinational.
  - wdata_o = req_data_i[g] when wr_en_o=1, else 0.
  - Transfer: beat counter +1.
  - Transfer with req_last_i[g]=1, or with beat counter == BURST-1: next edge → IDLE, gnt_o=0.
  - full_i=1: no transfer; beat counter holds; idle counter does not advance, since a full FIFO is not requester idleness.
  - req_valid_i[g]=0 and full_i=0: idle counter +1. Any transfer clears it.
  - Idle counter reaching TIMEOUT-1 with still no valid: next edge → IDLE, gnt_o=0.
- Minimum one IDLE cycle between consecutive grants; no back-to-back grants.
- A burst-limit release does not end the packet. The requester rearbitrates and continues the packet on a later grant.
- Simultaneous last and burst limit on the same beat: a single release.
- Requests from non-granted requesters are ignored during GRANT. Their valid must be held; no loss.
- Never writes while full_i=1. The block cannot cause a FIFO overflow.
- Counter widths: beat counter clog2(BURST)+1, idle counter clog2(TIMEOUT)+1; no wrap within a grant.

Test Plan:
- Reset: hold rst_i=1 with all req_valid_i=4'hF → gnt_o=0, wr_en_o=0, req_ready_o=0, busy_o=0. Assert rst_i mid-burst → all outputs 0 in the same cycle, without waiting for a clock edge.
- Single packet: requester 1 sends 0xA1, 0xA2, 0xA3 with last on 0xA3 and full_i=0 → gnt_o=4'b0010 one cycle after valid; wr_en_o high 3 consecutive cycles with wdata_o 0xA1, 0xA2, 0xA3; gnt_o=0 on the next edge.
- Round robin: all 4 requesters continuously valid with no last, BURST=4 → grant order 0,1,2,3,0; each grant exactly 4 writes; one idle cycle between grants; 16 writes in 20 cycles.
- Backpressure: requester 0 streaming 0x10..0x13; full_i=1 for 3 cycles after the 2nd beat → wr_en_o=0 and req_ready_o[0]=0 during those cycles; no timeout; resumes with 0x12, 0x13; FIFO receives 0x10..0x13 in order with no duplicates.
- Timeout: requester 2 granted; after 1 beat valid drops; requester 3 valid → grant released after 8 idle cycles; gnt_o=4'b1000 one cycle later.
- Pointer fairness: requester 0 finishes a packet while requesters 0 and 2 are both valid → next grant goes to 2, not 0.
